// File: rtl/array_ctrl_pkg.sv
// Shared types and defaults for the systolic-array job controller.
//   state_e          : controller FSM states
//   TIMEOUT_DEFAULT  : default cycle budget for any wait state
package array_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FETCH      = 3'd1,
        S_ISSUE      = 3'd2,
        S_WAIT       = 3'd3,
        S_DRAIN      = 3'd4,
        S_DRAIN_WAIT = 3'd5,
        S_DONE       = 3'd6
    } state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 64;

endpackage : array_ctrl_pkg

// File: rtl/done_collector.sv
// Sticky OR-mask collector: accumulates bits_i until clear_i, and reports
// when every bit has been seen, counting the current cycle's bits as well.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clear_i      : empty the mask at the next edge (wins over bits_i)
//   bits_i       : per-source completion bits, already qualified by caller
//   all_set_o    : combinational, (mask | bits_i) is all ones
module done_collector #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] bits_i,
    output logic             all_set_o
);

    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;

    assign mask_d    = mask_q | bits_i;
    assign all_set_o = &mask_d;

    // Mask register
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

endmodule : done_collector

// File: rtl/array_controller.sv
// Job sequencer for a ROWS x COLS PE grid: fetches edge operands wave by
// wave, broadcasts inputs_valid, waits for every PE, then drains the
// accumulators one column at a time.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   start_i, k_len_i : job start pulse and wave count (accepted in IDLE only)
//   busy_o           : controller not idle
//   operand_rd_o/idx : operand buffer request for wave operand_idx_o
//   operand_ack_i    : operands for the requested wave are on the grid edges
//   inputs_valid_o   : one-cycle broadcast to all PEs per wave
//   pe_done_i        : per-PE passthrough_valid, bit r*COLS+c
//   select_acc_o     : one-hot accumulator select for the column being drained
//   acc_valid_i      : per-PE accumulator_valid, bit r*COLS+c
//   result_valid_o   : one-cycle pulse, column result_col_o drained
//   done_o           : one-cycle job-complete pulse (first cycle back in IDLE)
//   error_o          : sticky timeout flag, cleared by the next accepted start
module array_controller
    import array_ctrl_pkg::*;
#(
    parameter  int unsigned ROWS    = 4,
    parameter  int unsigned COLS    = 4,
    parameter  int unsigned K_MAX   = 16,
    parameter  int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    localparam int unsigned KW      = $clog2(K_MAX + 1),
    localparam int unsigned IW      = (K_MAX > 1) ? $clog2(K_MAX) : 1,
    localparam int unsigned CW      = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int unsigned NPE     = ROWS * COLS
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [KW-1:0]   k_len_i,
    output logic            busy_o,
    output logic            operand_rd_o,
    output logic [IW-1:0]   operand_idx_o,
    input  logic            operand_ack_i,
    output logic            inputs_valid_o,
    input  logic [NPE-1:0]  pe_done_i,
    output logic [COLS-1:0] select_acc_o,
    input  logic [NPE-1:0]  acc_valid_i,
    output logic            result_valid_o,
    output logic [CW-1:0]   result_col_o,
    output logic            done_o,
    output logic            error_o
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_e          state_q;
    logic [KW-1:0]   k_len_q;
    logic [IW-1:0]   wave_idx_q;
    logic [CW-1:0]   col_q;
    logic [CW-1:0]   col_d;
    logic [TW-1:0]   tmo_q;

    logic [NPE-1:0]  pe_bits_c;
    logic [ROWS-1:0] acc_bits_c;
    logic            pe_all_set_c;
    logic            acc_all_set_c;
    logic            last_wave_c;
    logic            last_col_c;
    logic            tmo_expired_c;

    assign operand_idx_o = wave_idx_q;
    assign col_d         = col_q + CW'(1);
    assign last_wave_c   = (KW'(wave_idx_q) + KW'(1)) == k_len_q;
    assign last_col_c    = col_q == CW'(COLS - 1);
    assign tmo_expired_c = tmo_q == TW'(TIMEOUT - 1);

    // Completion bits only count in their own wait state
    assign pe_bits_c = pe_done_i & {NPE{state_q == S_WAIT}};

    // Pick out the acc_valid bits of the column being drained
    always_comb begin
        acc_bits_c = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                if (CW'(c) == col_q) begin
                    acc_bits_c[r] = acc_valid_i[r*COLS + c] & (state_q == S_DRAIN_WAIT);
                end
            end
        end
    end

    done_collector #(
        .WIDTH (NPE)
    ) u_pe_done (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (state_q == S_ISSUE),
        .bits_i    (pe_bits_c),
        .all_set_o (pe_all_set_c)
    );

    done_collector #(
        .WIDTH (ROWS)
    ) u_acc_done (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (state_q == S_DRAIN),
        .bits_i    (acc_bits_c),
        .all_set_o (acc_all_set_c)
    );

    // Controller FSM; every output is set on the edge that enters its state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            k_len_q        <= '0;
            wave_idx_q     <= '0;
            col_q          <= '0;
            tmo_q          <= '0;
            busy_o         <= 1'b0;
            operand_rd_o   <= 1'b0;
            inputs_valid_o <= 1'b0;
            select_acc_o   <= '0;
            result_valid_o <= 1'b0;
            result_col_o   <= '0;
            done_o         <= 1'b0;
            error_o        <= 1'b0;
        end else begin
            inputs_valid_o <= 1'b0;
            select_acc_o   <= '0;
            result_valid_o <= 1'b0;
            done_o         <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        k_len_q    <= k_len_i;
                        wave_idx_q <= '0;
                        error_o    <= 1'b0;
                        busy_o     <= 1'b1;
                        if (k_len_i == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            operand_rd_o <= 1'b1;
                            state_q      <= S_FETCH;
                        end
                    end
                end

                S_FETCH: begin
                    if (operand_ack_i) begin
                        operand_rd_o   <= 1'b0;
                        inputs_valid_o <= 1'b1;
                        state_q        <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    tmo_q   <= '0;
                    state_q <= S_WAIT;
                end

                S_WAIT: begin
                    if (pe_all_set_c) begin
                        if (last_wave_c) begin
                            col_q        <= '0;
                            select_acc_o <= COLS'(1);
                            state_q      <= S_DRAIN;
                        end else begin
                            wave_idx_q   <= wave_idx_q + IW'(1);
                            operand_rd_o <= 1'b1;
                            state_q      <= S_FETCH;
                        end
                    end else if (tmo_expired_c) begin
                        error_o <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end

                S_DRAIN: begin
                    tmo_q   <= '0;
                    state_q <= S_DRAIN_WAIT;
                end

                S_DRAIN_WAIT: begin
                    if (acc_all_set_c) begin
                        result_valid_o <= 1'b1;
                        result_col_o   <= col_q;
                        if (last_col_c) begin
                            state_q <= S_DONE;
                        end else begin
                            col_q        <= col_d;
                            select_acc_o <= COLS'(1) << col_d;
                            state_q      <= S_DRAIN;
                        end
                    end else if (tmo_expired_c) begin
                        error_o <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end

                S_DONE: begin
                    // Pulse lands on the first IDLE cycle, after any error_o update
                    done_o  <= 1'b1;
                    busy_o  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule : array_controller

// File: doc/array_controller.md
ARRAY_CONTROLLER -- requirements
Module: array_controller

Interface
REQ-001 The module SHALL have parameter ROWS, default 4, meaning the number of PE rows in the grid.
REQ-002 The module SHALL have parameter COLS, default 4, meaning the number of PE columns in the grid.
REQ-003 The module SHALL have parameter K_MAX, default 16, meaning the maximum number of MAC waves per job.
REQ-004 The module SHALL have parameter TIMEOUT, default 64, meaning the maximum cycles allowed in any wait state.
REQ-005 The module SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The module SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 The module SHALL have port start_i, input, 1 bit: job start pulse.
REQ-008 The module SHALL have port k_len_i, input, clog2(K_MAX+1) bits: number of waves, latched on accepted start.
REQ-009 The module SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-010 The module SHALL have port operand_rd_o, output, 1 bit: request to the edge operand buffers for wave operand_idx_o.
REQ-011 The module SHALL have port operand_idx_o, output, clog2(K_MAX) bits: current wave index.
REQ-012 The module SHALL have port operand_ack_i, input, 1 bit: the edge operands for operand_idx_o are on the grid edges and held until the next operand_rd_o.
REQ-013 The module SHALL have port inputs_valid_o, output, 1 bit: broadcast inputs_valid to all PEs.
REQ-014 The module SHALL have port pe_done_i, input, ROWS*COLS bits: passthrough_valid of each PE, bit index r*COLS+c.
REQ-015 The module SHALL have port select_acc_o, output, COLS bits: one-hot select_accumulator per column.
REQ-016 The module SHALL have port acc_valid_i, input, ROWS*COLS bits: accumulator_valid of each PE, same indexing as pe_done_i.
REQ-017 The module SHALL have port result_valid_o, output, 1 bit: one-cycle pulse when the column result_col_o has been drained.
REQ-018 The module SHALL have port result_col_o, output, clog2(COLS) bits: index of the drained column.
REQ-019 The module SHALL have port done_o, output, 1 bit: one-cycle job-complete pulse.
REQ-020 The module SHALL have port error_o, output, 1 bit: sticky timeout flag, cleared on the next accepted start.

Function
REQ-021 The FSM SHALL have states IDLE, FETCH, ISSUE, WAIT, DRAIN, DRAIN_WAIT and DONE.
REQ-022 start_i SHALL be accepted only in IDLE: it latches k_len_i, clears error_o and the wave index, and moves to FETCH on the next edge; start_i in any other state is ignored.
REQ-023 An accepted start with k_len_i=0 SHALL go directly to DONE: no operand_rd_o, no inputs_valid_o, no drain.
REQ-024 FETCH: operand_rd_o=1 (registered), held until operand_ack_i=1; on ack the FSM moves to ISSUE.
REQ-025 ISSUE: inputs_valid_o=1 for exactly one cycle; the done mask is cleared; the FSM then moves to WAIT.
REQ-026 WAIT: OR pe_done_i into a sticky ROWS*COLS mask each cycle; when the mask, including the current cycle's bits, is all ones, increment the wave index and go to FETCH, or to DRAIN after wave k_len-1.
REQ-027 DRAIN: select_acc_o=one-hot(col) for exactly one cycle, then DRAIN_WAIT; select_acc_o SHALL be zero in every other state.
REQ-028 DRAIN_WAIT: collect acc_valid_i bits of column col into a sticky ROWS-bit mask; when it is all ones, pulse result_valid_o with result_col_o=col, then go to DRAIN with col+1, or to DONE after column COLS-1.
REQ-029 DONE: done_o=1 for one cycle, then IDLE.
REQ-030 Timeout: a counter clears on entry to WAIT or DRAIN_WAIT; if it reaches TIMEOUT before completion, set error_o=1 and go to DONE.
REQ-031 Latency: start_i accepted at edge n gives operand_rd_o=1 at cycle n+1, and inputs_valid_o=1 one cycle after the ack cycle.
REQ-032 pe_done_i bits arriving outside WAIT, and acc_valid_i bits outside DRAIN_WAIT, SHALL be ignored.

Reset
REQ-033 When rst_i=1 at an edge, the FSM SHALL go to IDLE and all outputs, counters and masks SHALL be cleared to 0, including error_o, even mid-job.
REQ-034 The first start_i SHALL be accepted no earlier than the first edge with rst_i=0.

Structure
REQ-035 The state enum and the default TIMEOUT constant SHALL live in package array_ctrl_pkg.
REQ-036 The sticky mask collector SHALL be one sub-module, done_collector (parameter WIDTH; inputs clear, bits; output all_set), instantiated twice.
REQ-037 All outputs SHALL be registered.

Verification
REQ-038 k_len=3, ROWS=COLS=2, ack one cycle after each rd, pe_done all at once -> 3 inputs_valid pulses, then select_acc 01 and 10, result_col 0 then 1, one done_o, error_o=0.
REQ-039 pe_done bits arriving staggered over 5 cycles -> next operand_rd_o only after the last bit arrives.
REQ-040 One PE never asserts pe_done -> error_o=1 exactly TIMEOUT cycles after WAIT entry, then done_o, then IDLE.
REQ-041 k_len=0 -> done_o two cycles after start, with no rd, valid or select activity.
REQ-042 start_i re-asserted mid-job, then rst_i asserted in WAIT -> the second start is ignored, and all outputs are 0 and busy_o=0 after the reset edge.
